// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button step counter.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } press_state_t;

  // Converts a duration in milliseconds to a clock-cycle count.
  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/button_press_classifier.sv
// Turns one debounced button level into step pulses: one on press, then an
// auto-repeat stream once the button has been held past the long-press time.
module button_press_classifier
  import button_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned LONG_MS   = 500,
  parameter int unsigned REPEAT_MS = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic step
);

  localparam int unsigned LONG_CYC = ms_to_cycles(CLK_HZ, LONG_MS);
  localparam int unsigned REP_CYC  = ms_to_cycles(CLK_HZ, REPEAT_MS);
  localparam int unsigned MAX_CYC  = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
  localparam int unsigned TW       = $clog2(MAX_CYC);

  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYC - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REP_CYC - 1);

  if (LONG_CYC < 2 || REP_CYC < 2) begin : g_bad_timing
    $fatal(1, "button_press_classifier: LONG_CYC and REP_CYC must both be >= 2");
  end

  press_state_t  state;
  logic [TW-1:0] timer;

  // Press/hold/repeat classification; release always wins over a terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      timer <= '0;
      step  <= 1'b0;
    end else begin
      step <= 1'b0;
      unique case (state)
        IDLE: begin
          if (level) begin
            state <= HOLD;
            timer <= '0;
            step  <= 1'b1;
          end
        end
        HOLD: begin
          if (!level) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == LONG_LAST) begin
            state <= REPEAT;
            timer <= '0;
            step  <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        REPEAT: begin
          if (!level) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == REP_LAST) begin
            timer <= '0;
            step  <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_step_counter.sv
// Up/down LED counter driven by two push-buttons with press and auto-repeat.
module button_step_counter
  import button_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned LONG_MS   = 500,
  parameter int unsigned REPEAT_MS = 100,
  parameter int unsigned WIDTH     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             up_db,
  input  logic             down_db,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             up_step,
  output logic             down_step
);

  button_press_classifier #(
    .CLK_HZ   (CLK_HZ),
    .LONG_MS  (LONG_MS),
    .REPEAT_MS(REPEAT_MS)
  ) u_up (
    .clk    (clk),
    .reset_n(reset_n),
    .level  (up_db),
    .step   (up_step)
  );

  button_press_classifier #(
    .CLK_HZ   (CLK_HZ),
    .LONG_MS  (LONG_MS),
    .REPEAT_MS(REPEAT_MS)
  ) u_down (
    .clk    (clk),
    .reset_n(reset_n),
    .level  (down_db),
    .step   (down_step)
  );

  // Modular count: clear beats everything, coincident steps cancel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (up_step && down_step) begin
      count <= count;
    end else if (up_step) begin
      count <= count + WIDTH'(1);
    end else if (down_step) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_button_step_counter.sv
// Directed bench for button_step_counter with a run-length reference model.
module tb_button_step_counter;

  localparam int unsigned CLK_HZ    = 1000;
  localparam int unsigned LONG_MS   = 5;
  localparam int unsigned REPEAT_MS = 2;
  localparam int unsigned WIDTH     = 4;
  localparam int          LONG      = CLK_HZ / 1000 * LONG_MS;
  localparam int          REP       = CLK_HZ / 1000 * REPEAT_MS;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             up_db = 1'b0;
  logic             down_db = 1'b0;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] count;
  logic             up_step;
  logic             down_step;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  button_step_counter #(
    .CLK_HZ   (CLK_HZ),
    .LONG_MS  (LONG_MS),
    .REPEAT_MS(REPEAT_MS),
    .WIDTH    (WIDTH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .up_db    (up_db),
    .down_db  (down_db),
    .clear    (clear),
    .count    (count),
    .up_step  (up_step),
    .down_step(down_step)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // A step is due on the 1st high sample of a press, then LONG samples later,
  // then every REP samples after that.
  function automatic logic step_due(input int run);
    return (run == 1) || (run >= LONG + 1 && ((run - 1 - LONG) % REP) == 0);
  endfunction

  int               up_run = 0;
  int               down_run = 0;
  logic             exp_up = 1'b0;
  logic             exp_down = 1'b0;
  logic [WIDTH-1:0] exp_count = '0;

  // Reference model: run lengths of the button levels and the resulting count.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up_run    <= 0;
      down_run  <= 0;
      exp_up    <= 1'b0;
      exp_down  <= 1'b0;
      exp_count <= '0;
    end else begin
      up_run   <= up_db ? up_run + 1 : 0;
      down_run <= down_db ? down_run + 1 : 0;
      exp_up   <= up_db && step_due(up_run + 1);
      exp_down <= down_db && step_due(down_run + 1);
      if (clear)                    exp_count <= '0;
      else if (exp_up && exp_down)  exp_count <= exp_count;
      else if (exp_up)              exp_count <= exp_count + 1'b1;
      else if (exp_down)            exp_count <= exp_count - 1'b1;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("count", int'(count), int'(exp_count));
      check("up_step", int'(up_step), int'(exp_up));
      check("down_step", int'(down_step), int'(exp_down));
    end
  end

  task automatic press(input logic u, input logic d, input int n);
    up_db   = u;
    down_db = d;
    repeat (n) @(negedge clk);
    up_db   = 1'b0;
    down_db = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    check("reset_count", int'(count), 0);
    check("reset_up_step", int'(up_step), 0);

    // Short press from reset.
    press(1'b1, 1'b0, 3);
    check("short_press", int'(count), 1);

    // Clear, then a 12-cycle hold: initial step plus four repeats.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_level", int'(count), 0);
    press(1'b1, 1'b0, 12);
    check("long_hold", int'(count), 5);

    // Wrap both ways.
    for (int i = 0; i < 10; i++) press(1'b1, 1'b0, 1);
    check("count_to_max", int'(count), 15);
    press(1'b1, 1'b0, 1);
    check("wrap_up", int'(count), 0);
    press(1'b0, 1'b1, 1);
    check("wrap_down", int'(count), 15);

    // Coincident presses cancel.
    press(1'b1, 1'b1, 1);
    check("coincident", int'(count), 15);

    // Clear in the cycle the up step would be applied.
    up_db = 1'b1;
    @(negedge clk);
    up_db = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (2) @(negedge clk);
    check("clear_with_step", int'(count), 0);

    // Release exactly when the long-press timer is at its terminal value.
    press(1'b1, 1'b0, 5);
    check("release_terminal", int'(count), 1);

    // Clear while holding: classifier keeps repeating through the clear.
    up_db = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    repeat (6) @(negedge clk);
    up_db = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_through_clear", int'(count), 3);

    // Async reset mid-repeat with the button still held.
    up_db = 1'b1;
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_count", int'(count), 0);
    check("async_reset_up_step", int'(up_step), 0);
    check("async_reset_down_step", int'(down_step), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    up_db = 1'b0;
    repeat (3) @(negedge clk);
    check("after_reset_hold", int'(count), 3);

    // Down hold: initial step plus one repeat.
    press(1'b0, 1'b1, 7);
    check("down_hold", int'(count), 1);

    // Both held together: every pulse coincides and cancels.
    press(1'b1, 1'b1, 8);
    check("both_held", int'(count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
